axi_sram_slave: RTL and testbench



---
 rtl/axi_sram_slave_pkg.sv | 49 ++++
 rtl/axi_sram_mem.sv | 33 +++
 rtl/axi_sram_slave.sv | 188 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - AXI3 constants, FSM encodings and burst helpers for the SRAM slave
package axi_sram_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Burst context latched at the address handshake; only the low 4 bits of len are honoured.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_cmd_t;

  // Address of the following beat. WRAP and the reserved code walk like INCR;
  // sizes above 4 bytes are clamped to 4 bytes since the data path is one word.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
    logic [31:0] step;
    step = 32'd1 << ((size > AXI_SIZE_4B) ? AXI_SIZE_4B : size);
    case (burst)
      AXI_BURST_FIXED:                axi_next_addr = addr;
      AXI_BURST_INCR, AXI_BURST_WRAP: axi_next_addr = addr + step;
      default:                        axi_next_addr = addr + step;
    endcase
  endfunction

  // Attributes this slave cannot honour exactly; the burst still runs but answers SLVERR.
  function automatic logic axi_attr_err(input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic [1:0] burst);
    axi_attr_err = (len[7:4] != 4'd0) || (size > AXI_SIZE_4B) || burst[1];
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// rtl/axi_sram_mem.sv - word array with one async read port and one byte-enable write port
module axi_sram_mem
  import axi_sram_slave_pkg::*;
#(
  parameter  int MEM_WORDS = 1024,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_strb,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [MEM_WORDS];

  // Read is combinational, so a read loaded on the same edge as a write sees the old word.
  assign rd_data = mem[rd_idx];

  // Commit only the byte lanes selected by the strobe; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 32-bit slave with independent read/write engines over internal SRAM
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [0:0]       r_state;
  axi_cmd_t         r_cmd;
  logic [3:0]       r_beat;
  logic [31:0]      r_next_addr;
  logic [IDX_W-1:0] r_load_idx;
  logic [31:0]      mem_rdata;

  logic [1:0]       w_state;
  axi_cmd_t         w_cmd;
  logic [3:0]       w_beat;
  logic             w_err;
  logic [ID_W-1:0]  w_id;
  logic [31:0]      w_next_addr;
  logic             w_last_beat;
  logic             w_last_err;

  logic             ar_hs;
  logic             r_hs;
  logic             aw_hs;
  logic             w_hs;

  // Sideband attributes and wid carry no meaning for a flat single-port SRAM.
  logic             unused_sideband;
  assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign arready = (r_state == R_IDLE);
  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // The read port looks at araddr while idle (beat 0) and at the following beat while bursting.
  assign r_next_addr = axi_next_addr(r_cmd.addr, r_cmd.size, r_cmd.burst);
  assign r_load_idx  = (r_state == R_IDLE) ? araddr[IDX_W+1:2] : r_next_addr[IDX_W+1:2];

  // The beat counter alone ends a write burst; wlast is only audited for the response.
  assign w_next_addr = axi_next_addr(w_cmd.addr, w_cmd.size, w_cmd.burst);
  assign w_last_beat = (w_beat == w_cmd.len);
  assign w_last_err  = (wlast != w_last_beat);

  axi_sram_mem #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .rd_idx  (r_load_idx),
    .rd_data (mem_rdata),
    .wr_en   (w_hs),
    .wr_idx  (w_cmd.addr[IDX_W+1:2]),
    .wr_strb (wstrb),
    .wr_data (wdata)
  );

  // Read engine: latch the AR command, then present one registered beat per accepted R handshake.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_cmd   <= '0;
      r_beat  <= 4'd0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= 32'd0;
      rid     <= '0;
      rresp   <= AXI_RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        r_cmd   <= '{addr: araddr, len: arlen[3:0], size: arsize, burst: arburst};
        r_beat  <= 4'd0;
        rdata   <= mem_rdata;
        rid     <= arid;
        rresp   <= axi_attr_err(arlen, arsize, arburst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rlast   <= (arlen[3:0] == 4'd0);
        rvalid  <= 1'b1;
        r_state <= R_DATA;
      end
    end else if (r_hs) begin
      if (r_beat == r_cmd.len) begin
        rvalid  <= 1'b0;
        rlast   <= 1'b0;
        r_state <= R_IDLE;
      end else begin
        r_cmd.addr <= r_next_addr;
        r_beat     <= r_beat + 4'd1;
        rdata      <= mem_rdata;
        rlast      <= ((r_beat + 4'd1) == r_cmd.len);
      end
    end
  end

  // Write engine: AW latch, accept beats until the counted last one, then hold B until taken.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_cmd   <= '0;
      w_beat  <= 4'd0;
      w_err   <= 1'b0;
      w_id    <= '0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= AXI_RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_cmd   <= '{addr: awaddr, len: awlen[3:0], size: awsize, burst: awburst};
            w_id    <= awid;
            w_err   <= axi_attr_err(awlen, awsize, awburst);
            w_beat  <= 4'd0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_cmd.addr <= w_next_addr;
            w_beat     <= w_beat + 4'd1;
            if (w_last_beat) begin
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err | w_last_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              w_state <= W_RESP;
            end else if (w_last_err) begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed and randomized self-checking bench for axi_sram_slave
module tb_axi_sram_slave;

  localparam int ID_W      = 4;
  localparam int MEM_WORDS = 1024;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic [ID_W-1:0] arid = '0;
  logic [31:0]     araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = '0;
  logic [1:0]      arburst = '0;
  logic [1:0]      arlock = '0;
  logic [3:0]      arcache = '0;
  logic [2:0]      arprot = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [ID_W-1:0] awid = '0;
  logic [31:0]     awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = '0;
  logic [1:0]      awburst = '0;
  logic [1:0]      awlock = '0;
  logic [3:0]      awcache = '0;
  logic [2:0]      awprot = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [ID_W-1:0] wid = '0;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model [int];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];

  always #5 clk = ~clk;

  axi_sram_slave #(.ID_W(ID_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i computed directly from the start address.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    int step;
    step = (size > 3'd2) ? 4 : (1 << size);
    if (burst == 2'b00) return a;
    return a + 32'(i * step);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & 32'(MEM_WORDS - 1));
  endfunction

  function automatic logic [1:0] attr_resp(input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
    return (len > 8'd15 || size > 3'd2 || burst >= 2'b10) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input int w);
    return model.exists(w) ? model[w] : 32'h0;
  endfunction

  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = model_rd(w);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    model[w] = v;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                          output logic [1:0] resp_o, output logic [ID_W-1:0] id_o);
    int L, cnt;
    L = int'(len[3:0]);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
    check("aw_ready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= L; i++) begin
      wdata  = wq_data[i];
      wstrb  = wq_strb[i];
      wlast  = (wlast_at < 0) ? (i == L) : (i == wlast_at);
      wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin @(negedge clk); cnt++; end
      check("w_ready", 32'(wready), 32'd1);
      model_write(word_of(beat_addr(addr, size, burst, i)), wq_data[i], wq_strb[i]);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("w_ready_drop", 32'(wready), 32'd0);
    bready = 1'b1;
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    check("b_valid", 32'(bvalid), 32'd1);
    resp_o = bresp;
    id_o   = bid;
    @(negedge clk);
    bready = 1'b0;
    check("b_valid_drop", 32'(bvalid), 32'd0);
    check("aw_ready_back", 32'(awready), 32'd1);
  endtask

  // mode 0: rready always high, 1: alternating, 2: random.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode,
                         output logic [31:0] first_data);
    int L, nb, cyc, cnt, first_cyc, last_cyc;
    logic stalled, rr;
    logic [31:0] sd;
    logic [ID_W-1:0] sid;
    logic [1:0] er;
    L  = int'(len[3:0]);
    er = attr_resp(len, size, burst);
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin @(negedge clk); cnt++; end
    check("ar_ready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    nb = 0; cyc = 0; stalled = 1'b0; first_cyc = 0; last_cyc = 0;
    first_data = 32'h0; sd = 32'h0; sid = '0;
    while (nb <= L && cyc < 200) begin
      if (stalled) begin
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, sd);
        check("r_hold_id", 32'(rid), 32'(sid));
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      rready = rr;
      if (rvalid && rr) begin
        check("r_data", rdata, model_rd(word_of(beat_addr(addr, size, burst, nb))));
        check("r_id", 32'(rid), 32'(id));
        check("r_resp", 32'(rresp), 32'(er));
        check("r_last", 32'(rlast), 32'(nb == L));
        if (nb == 0) begin first_cyc = cyc; first_data = rdata; end
        last_cyc = cyc;
        nb++;
      end
      stalled = rvalid && !rr;
      sd  = rdata;
      sid = rid;
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check("r_beat_count", 32'(nb), 32'(L + 1));
    if (mode == 0) check("r_back_to_back", 32'(last_cyc - first_cyc), 32'(L));
    check("r_valid_drop", 32'(rvalid), 32'd0);
    check("ar_ready_back", 32'(arready), 32'd1);
  endtask

  task automatic load_words(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [31:0] a3, input int n);
    logic [31:0] src [4];
    src = '{a0, a1, a2, a3};
    wq_data.delete();
    wq_strb.delete();
    for (int i = 0; i < n; i++) begin
      wq_data.push_back(src[i]);
      wq_strb.push_back(4'hF);
    end
  endtask

  initial begin
    logic [1:0]      resp, resp5;
    logic [ID_W-1:0] bid_o, bid5;
    logic [31:0]     fd, fd5;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst, exp_resp;
    int              L, wl_at, mode;

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    aresetn = 1'b1;
    @(negedge clk);

    load_words(32'hDEADBEEF, 0, 0, 0, 1);
    do_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, -1, resp, bid_o);
    check("t1_bresp", 32'(resp), 32'd0);
    check("t1_bid", 32'(bid_o), 32'd3);
    do_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 0, fd);
    check("t1_rdata", fd, 32'hDEADBEEF);

    load_words(32'h11, 32'h22, 32'h33, 32'h44, 4);
    do_write(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, -1, resp, bid_o);
    check("t2_bresp", 32'(resp), 32'd0);
    do_read(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 0, fd);
    check("t2_first", fd, 32'h11);
    do_read(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 1, fd);

    load_words(32'h11223344, 0, 0, 0, 1);
    do_write(4'd0, 32'h200, 8'd0, 3'd2, 2'b01, -1, resp, bid_o);
    wq_data = '{32'h0000AB00};
    wq_strb = '{4'b0010};
    do_write(4'd0, 32'h200, 8'd0, 3'd2, 2'b01, -1, resp, bid_o);
    do_read(4'd0, 32'h200, 8'd0, 3'd2, 2'b01, 0, fd);
    check("t4_byte_merge", fd, 32'h1122AB44);

    load_words(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 4);
    fork
      do_write(4'd1, 32'h300, 8'd3, 3'd2, 2'b01, -1, resp5, bid5);
      do_read(4'd0, 32'h100, 8'd3, 3'd2, 2'b01, 0, fd5);
    join
    check("t5_bresp", 32'(resp5), 32'd0);
    check("t5_bid", 32'(bid5), 32'd1);
    check("t5_rfirst", fd5, 32'h11);
    do_read(4'd4, 32'h300, 8'd3, 3'd2, 2'b01, 2, fd);
    check("t5_wfirst", fd, 32'hA0A0A0A0);
    do_read(4'd6, 32'h100, 8'd3, 3'd2, 2'b10, 0, fd);
    do_read(4'd7, 32'h100, 8'h13, 3'd3, 2'b01, 1, fd);

    load_words(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 4);
    do_write(4'd8, 32'h400, 8'd3, 3'd2, 2'b01, 1, resp, bid_o);
    check("t6_bresp_early_wlast", 32'(resp), 32'd2);
    check("t6_bid", 32'(bid_o), 32'd8);
    do_read(4'd8, 32'h400, 8'd3, 3'd2, 2'b01, 0, fd);

    for (int k = 0; k < 4; k++) begin
      wq_data.delete();
      wq_strb.delete();
      for (int i = 0; i < 16; i++) begin
        wq_data.push_back($urandom);
        wq_strb.push_back(4'hF);
      end
      do_write(4'(k), 32'((512 + 16 * k) * 4), 8'd15, 3'd2, 2'b01, -1, resp, bid_o);
      check("fill_bresp", 32'(resp), 32'd0);
    end

    for (int it = 0; it < 30; it++) begin
      L     = $urandom_range(0, 15);
      len   = {($urandom_range(0, 5) == 0) ? 4'h1 : 4'h0, 4'(L)};
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 2));
      addr  = 32'((512 + $urandom_range(0, 47)) * 4);
      wl_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L)) : -1;
      wq_data.delete();
      wq_strb.delete();
      for (int i = 0; i <= L; i++) begin
        wq_data.push_back($urandom);
        wq_strb.push_back(4'($urandom_range(0, 15)));
      end
      exp_resp = attr_resp(len, size, burst);
      if (wl_at >= 0 && wl_at != L) exp_resp = 2'b10;
      bid_o = 4'($urandom_range(0, 15));
      do_write(bid_o, addr, len, size, burst, wl_at, resp, bid5);
      check("rnd_bresp", 32'(resp), 32'(exp_resp));
      check("rnd_bid", 32'(bid5), 32'(bid_o));
      mode = $urandom_range(0, 2);
      do_read(4'($urandom_range(0, 15)), addr, len, size, burst, mode, fd);
    end

    @(negedge clk);
    arid = 4'd6; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("mid_rvalid_before_reset", 32'(rvalid), 32'd1);
    aresetn = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    do_read(4'd7, 32'h100, 8'd3, 3'd2, 2'b01, 0, fd);
    check("post_rst_first", fd, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
